// File: rtl/serv_axi_sram_responder.sv
// AXI4 subordinate backed by a word-organised SRAM. It has independent single-outstanding
// read and write engines, FIXED/INCR bursts and per-beat range/size checking.
module serv_axi_sram_responder #(
  parameter int unsigned MEMSIZE  = 8192,
  parameter int unsigned AW       = 13,
  parameter int unsigned ID_WIDTH = 1,
  parameter string       MEMFILE  = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_WIDTH-1:0] i_awsid,
  input  logic [AW-1:0]       i_awsaddr,
  input  logic [7:0]          i_aws_len,
  input  logic [2:0]          i_aws_size,
  input  logic [1:0]          i_aws_burst,
  input  logic                i_awsvalid,
  output logic                o_awsready,
  input  logic [31:0]         i_wsdata,
  input  logic [3:0]          i_wsstrb,
  input  logic                i_ws_last,
  input  logic                i_wsvalid,
  output logic                o_wsready,
  output logic [ID_WIDTH-1:0] o_bsid,
  output logic [1:0]          o_bsresp,
  output logic                o_bsvalid,
  input  logic                i_bsready,
  input  logic [ID_WIDTH-1:0] i_arsid,
  input  logic [AW-1:0]       i_arsaddr,
  input  logic [7:0]          i_ars_len,
  input  logic [2:0]          i_ars_size,
  input  logic [1:0]          i_ars_burst,
  input  logic                i_arsvalid,
  output logic                o_arsready,
  output logic [ID_WIDTH-1:0] o_rsid,
  output logic [31:0]         o_rsdata,
  output logic [1:0]          o_rsresp,
  output logic                o_rs_last,
  output logic                o_rsvalid,
  input  logic                i_rsready
);

  localparam int unsigned IDXW        = $clog2(MEMSIZE / 4);
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA} rstate_t;

  logic [31:0] r_mem [0:MEMSIZE/4-1];

  // WRAP and reserved bursts are rejected beat by beat, as are oversize and out-of-range beats
  function automatic logic beatErr(input logic [AW-1:0] addr, input logic [2:0] size,
                                   input logic [1:0] burst);
    return (32'(addr) >= MEMSIZE) || (size > 3'd2) || burst[1];
  endfunction

  function automatic logic [AW-1:0] nextAddr(input logic [AW-1:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + (AW'(1) << size);
  endfunction

  wstate_t             r_wstate, w_wnext;
  logic [ID_WIDTH-1:0] r_wid;
  logic [AW-1:0]       r_waddr;
  logic [7:0]          r_wlen, r_wcnt;
  logic [2:0]          r_wsize;
  logic [1:0]          r_wburst;
  logic                r_werr;
  logic                w_awhs, w_whs, w_wlastbeat, w_wbeaterr;

  assign w_awhs      = (r_wstate == W_IDLE) && i_awsvalid;
  assign w_whs       = (r_wstate == W_DATA) && i_wsvalid;
  assign w_wlastbeat = (r_wcnt == r_wlen);
  assign w_wbeaterr  = beatErr(r_waddr, r_wsize, r_wburst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wnext;
  end

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_awhs) w_wnext = W_DATA;
      W_DATA:  if (w_whs && w_wlastbeat) w_wnext = W_RESP;
      W_RESP:  if (i_bsready) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_werr   <= 1'b0;
    end else if (w_awhs) begin
      r_wid    <= i_awsid;
      r_waddr  <= i_awsaddr;
      r_wlen   <= i_aws_len;
      r_wcnt   <= '0;
      r_wsize  <= i_aws_size;
      r_wburst <= i_aws_burst;
      r_werr   <= 1'b0;
    end else if (w_whs) begin
      r_wcnt  <= r_wcnt + 8'd1;
      r_waddr <= nextAddr(r_waddr, r_wsize, r_wburst);
      if (w_wbeaterr || (i_ws_last != w_wlastbeat)) r_werr <= 1'b1;
    end
  end

  // A mis-flagged last still writes; only range/size/burst errors suppress the store
  always_ff @(posedge clk) begin
    if (w_whs && !w_wbeaterr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wsstrb[b]) r_mem[r_waddr[IDXW+1:2]][b*8 +: 8] <= i_wsdata[b*8 +: 8];
      end
    end
  end

  assign o_awsready = (r_wstate == W_IDLE);
  assign o_wsready  = (r_wstate == W_DATA);
  assign o_bsvalid  = (r_wstate == W_RESP);
  assign o_bsid     = (r_wstate == W_RESP) ? r_wid : '0;
  assign o_bsresp   = ((r_wstate == W_RESP) && r_werr) ? RESP_SLVERR : 2'b00;

  rstate_t             r_rstate, w_rnext;
  logic [ID_WIDTH-1:0] r_rid;
  logic [AW-1:0]       r_raddr;
  logic [7:0]          r_rlen, r_rcnt;
  logic [2:0]          r_rsize;
  logic [1:0]          r_rburst;
  logic [31:0]         r_rsdata;
  logic [1:0]          r_rsresp;
  logic                r_rs_last;
  logic                w_arhs, w_rhs, w_ferr, w_flast;
  logic [AW-1:0]       w_faddr;
  logic [2:0]          w_fsize;
  logic [1:0]          w_fburst;

  assign w_arhs = (r_rstate == R_IDLE) && i_arsvalid;
  assign w_rhs  = (r_rstate == R_DATA) && i_rsready;

  // The next beat is fetched into the output register at the handshake edge, so a write
  // landing on the same edge is not yet visible and a stalled beat cannot change
  assign w_faddr  = w_arhs ? i_arsaddr   : nextAddr(r_raddr, r_rsize, r_rburst);
  assign w_fsize  = w_arhs ? i_ars_size  : r_rsize;
  assign w_fburst = w_arhs ? i_ars_burst : r_rburst;
  assign w_flast  = w_arhs ? (i_ars_len == 8'd0) : ((r_rcnt + 8'd1) == r_rlen);
  assign w_ferr   = beatErr(w_faddr, w_fsize, w_fburst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_arhs) w_rnext = R_DATA;
      R_DATA:  if (w_rhs && r_rs_last) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rid     <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rsdata  <= '0;
      r_rsresp  <= '0;
      r_rs_last <= 1'b0;
    end else if (w_arhs || (w_rhs && !r_rs_last)) begin
      if (w_arhs) begin
        r_rid    <= i_arsid;
        r_rlen   <= i_ars_len;
        r_rsize  <= i_ars_size;
        r_rburst <= i_ars_burst;
        r_rcnt   <= '0;
      end else begin
        r_rcnt <= r_rcnt + 8'd1;
      end
      r_raddr   <= w_faddr;
      r_rsdata  <= w_ferr ? 32'd0 : r_mem[w_faddr[IDXW+1:2]];
      r_rsresp  <= w_ferr ? RESP_SLVERR : 2'b00;
      r_rs_last <= w_flast;
    end else if (w_rhs) begin
      r_rsdata  <= '0;
      r_rsresp  <= '0;
      r_rs_last <= 1'b0;
    end
  end

  assign o_arsready = (r_rstate == R_IDLE);
  assign o_rsvalid  = (r_rstate == R_DATA);
  assign o_rsid     = (r_rstate == R_DATA) ? r_rid : '0;
  assign o_rsdata   = r_rsdata;
  assign o_rsresp   = r_rsresp;
  assign o_rs_last  = r_rs_last;

endmodule

// File: tb/tb_serv_axi_sram_responder.sv
// Directed scoreboard bench for serv_axi_sram_responder: expected B/R responses are queued
// when a transaction is issued and checked as the responder returns them.
module tb_serv_axi_sram_responder;

  localparam int unsigned MEMSIZE = 8192;
  localparam int unsigned AW      = 14;
  localparam int unsigned IDW     = 2;
  localparam logic [1:0]  FIXED   = 2'b00;
  localparam logic [1:0]  INCR    = 2'b01;
  localparam logic [1:0]  WRAP    = 2'b10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [IDW-1:0] i_awsid = '0;
  logic [AW-1:0]  i_awsaddr = '0;
  logic [7:0]     i_aws_len = '0;
  logic [2:0]     i_aws_size = '0;
  logic [1:0]     i_aws_burst = '0;
  logic           i_awsvalid = 1'b0;
  logic           o_awsready;
  logic [31:0]    i_wsdata = '0;
  logic [3:0]     i_wsstrb = '0;
  logic           i_ws_last = 1'b0;
  logic           i_wsvalid = 1'b0;
  logic           o_wsready;
  logic [IDW-1:0] o_bsid;
  logic [1:0]     o_bsresp;
  logic           o_bsvalid;
  logic           i_bsready = 1'b0;
  logic [IDW-1:0] i_arsid = '0;
  logic [AW-1:0]  i_arsaddr = '0;
  logic [7:0]     i_ars_len = '0;
  logic [2:0]     i_ars_size = '0;
  logic [1:0]     i_ars_burst = '0;
  logic           i_arsvalid = 1'b0;
  logic           o_arsready;
  logic [IDW-1:0] o_rsid;
  logic [31:0]    o_rsdata;
  logic [1:0]     o_rsresp;
  logic           o_rs_last;
  logic           o_rsvalid;
  logic           i_rsready = 1'b0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           last;
    logic [1:0]     resp;
    logic [31:0]    data;
  } rexp_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } bexp_t;

  rexp_t rExpQ[$];
  bexp_t bExpQ[$];
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  serv_axi_sram_responder #(
    .MEMSIZE(MEMSIZE), .AW(AW), .ID_WIDTH(IDW), .MEMFILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_awsid(i_awsid), .i_awsaddr(i_awsaddr), .i_aws_len(i_aws_len), .i_aws_size(i_aws_size),
    .i_aws_burst(i_aws_burst), .i_awsvalid(i_awsvalid), .o_awsready(o_awsready),
    .i_wsdata(i_wsdata), .i_wsstrb(i_wsstrb), .i_ws_last(i_ws_last), .i_wsvalid(i_wsvalid),
    .o_wsready(o_wsready),
    .o_bsid(o_bsid), .o_bsresp(o_bsresp), .o_bsvalid(o_bsvalid), .i_bsready(i_bsready),
    .i_arsid(i_arsid), .i_arsaddr(i_arsaddr), .i_ars_len(i_ars_len), .i_ars_size(i_ars_size),
    .i_ars_burst(i_ars_burst), .i_arsvalid(i_arsvalid), .o_arsready(o_arsready),
    .o_rsid(o_rsid), .o_rsdata(o_rsdata), .o_rsresp(o_rsresp), .o_rs_last(o_rs_last),
    .o_rsvalid(o_rsvalid), .i_rsready(i_rsready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic queueFault(input string tag);
    total++;
    bad++;
    $error("[TB] FAIL %s observed=empty expected=entry", tag);
  endtask

  task automatic expectR(input int id, input logic [31:0] data, input int resp, input bit last);
    rexp_t e;
    e.id = IDW'(id); e.last = last; e.resp = 2'(resp); e.data = data;
    rExpQ.push_back(e);
  endtask

  task automatic awSend(input int id, input int addr, input int len, input int size,
                        input logic [1:0] burst);
    int w = 0;
    i_awsid = IDW'(id); i_awsaddr = AW'(addr); i_aws_len = 8'(len);
    i_aws_size = 3'(size); i_aws_burst = burst; i_awsvalid = 1'b1;
    while (o_awsready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    checkOutput("aw_accept", 64'(o_awsready), 64'(1'b1));
    @(negedge clk);
    i_awsvalid = 1'b0;
    checkOutput("w_ready_after_aw", 64'({o_awsready, o_wsready}), 64'(2'b01));
  endtask

  task automatic wSend(input logic [31:0] data, input logic [3:0] strb, input bit last);
    int w = 0;
    i_wsdata = data; i_wsstrb = strb; i_ws_last = last; i_wsvalid = 1'b1;
    while (o_wsready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    checkOutput("w_accept", 64'(o_wsready), 64'(1'b1));
    @(negedge clk);
    i_wsvalid = 1'b0; i_ws_last = 1'b0;
  endtask

  task automatic arSend(input int id, input int addr, input int len, input int size,
                        input logic [1:0] burst);
    int w = 0;
    i_arsid = IDW'(id); i_arsaddr = AW'(addr); i_ars_len = 8'(len);
    i_ars_size = 3'(size); i_ars_burst = burst; i_arsvalid = 1'b1;
    while (o_arsready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    checkOutput("ar_accept", 64'(o_arsready), 64'(1'b1));
    @(negedge clk);
    i_arsvalid = 1'b0;
    checkOutput("r_valid_after_ar", 64'({o_arsready, o_rsvalid}), 64'(2'b01));
  endtask

  task automatic bRecv(input bit stall);
    bexp_t e;
    int    w = 0;
    int    k;
    if (bExpQ.size() == 0) begin queueFault("b_queue"); return; end
    e = bExpQ.pop_front();
    while (o_bsvalid !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    checkOutput("b_latency", 64'(w), 64'(0));
    if (stall) begin
      k = $urandom_range(1, 4);
      repeat (k) begin
        checkOutput("b_hold", 64'({o_bsvalid, o_bsid, o_bsresp}), 64'({1'b1, e}));
        @(negedge clk);
      end
    end
    i_bsready = 1'b1;
    checkOutput("b_resp", 64'({o_bsid, o_bsresp}), 64'(e));
    @(negedge clk);
    i_bsready = 1'b0;
    checkOutput("aw_ready_after_b", 64'({o_awsready, o_bsvalid}), 64'(2'b10));
  endtask

  task automatic rRecv(input int n, input bit stall);
    rexp_t e;
    int    w;
    int    k;
    for (int i = 0; i < n; i++) begin
      if (rExpQ.size() == 0) begin queueFault("r_queue"); return; end
      e = rExpQ.pop_front();
      w = 0;
      while (o_rsvalid !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      checkOutput("r_latency", 64'(w), 64'(0));
      if (stall) begin
        i_rsready = 1'b0;
        k = $urandom_range(1, 3);
        repeat (k) begin
          checkOutput("r_hold", 64'({o_rsvalid, o_rsid, o_rs_last, o_rsresp, o_rsdata}),
                      64'({1'b1, e}));
          @(negedge clk);
        end
      end
      i_rsready = 1'b1;
      checkOutput("r_beat", 64'({o_rsid, o_rs_last, o_rsresp, o_rsdata}), 64'(e));
      @(negedge clk);
      if (e.last) checkOutput("ar_ready_after_r", 64'({o_arsready, o_rsvalid}), 64'(2'b10));
    end
    i_rsready = 1'b0;
  endtask

  // One complete write burst with correct last flags, data = base + step*beat
  task automatic applyStimulus(input int id, input int addr, input int len, input int size,
                               input logic [1:0] burst, input logic [31:0] base,
                               input logic [31:0] step, input logic [3:0] strb,
                               input int resp, input bit bStall);
    bexp_t e;
    e.id = IDW'(id); e.resp = 2'(resp);
    bExpQ.push_back(e);
    awSend(id, addr, len, size, burst);
    for (int i = 0; i <= len; i++) wSend(base + step * 32'(i), strb, i == len);
    bRecv(bStall);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bexp_t be;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 64'({o_awsready, o_arsready, o_wsready}), 64'(3'b110));
    checkOutput("rst_valid", 64'({o_bsvalid, o_rsvalid}), 64'(2'b00));
    checkOutput("rst_b", 64'({o_bsid, o_bsresp}), 64'(0));
    checkOutput("rst_r", 64'({o_rsid, o_rs_last, o_rsresp, o_rsdata}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single write then read");
    applyStimulus(1, 'h10, 0, 2, INCR, 32'hDEADBEEF, 32'd0, 4'hF, 0, 1'b0);
    expectR(1, 32'hDEADBEEF, 0, 1'b1);
    arSend(1, 'h10, 0, 2, INCR);
    rRecv(1, 1'b0);

    $display("[TB] INCR burst with halfword strobes, back-to-back read");
    applyStimulus(0, 'h100, 3, 2, INCR, 32'hFFFFFFFF, 32'd0, 4'hF, 0, 1'b0);
    applyStimulus(2, 'h100, 3, 2, INCR, 32'h12341000, 32'd1, 4'h3, 0, 1'b0);
    for (int i = 0; i < 4; i++) expectR(3, 32'hFFFF1000 + 32'(i), 0, i == 3);
    i_rsready = 1'b1;
    arSend(3, 'h100, 3, 2, INCR);
    rRecv(4, 1'b0);

    $display("[TB] FIXED burst");
    applyStimulus(0, 'h20, 2, 2, FIXED, 32'd1, 32'd1, 4'hF, 0, 1'b0);
    expectR(0, 32'd3, 0, 1'b1);
    arSend(0, 'h20, 0, 2, INCR);
    rRecv(1, 1'b0);

    $display("[TB] error responses");
    applyStimulus(0, 'h0, 0, 2, INCR, 32'h600DCAFE, 32'd0, 4'hF, 0, 1'b0);
    applyStimulus(2, 'h2000, 0, 2, INCR, 32'h12345678, 32'd0, 4'hF, 2, 1'b0);
    expectR(2, 32'h600DCAFE, 0, 1'b1);
    arSend(2, 'h0, 0, 2, INCR);
    rRecv(1, 1'b0);
    expectR(1, 32'd0, 2, 1'b1);
    arSend(1, 'h10, 0, 3, INCR);
    rRecv(1, 1'b0);
    for (int i = 0; i < 4; i++) expectR(0, 32'd0, 2, i == 3);
    arSend(0, 'h100, 3, 2, WRAP);
    rRecv(4, 1'b0);
    applyStimulus(3, 'h600, 1, 2, WRAP, 32'h66660000, 32'd1, 4'hF, 2, 1'b0);

    $display("[TB] last-flag mismatch");
    be.id = 2'd1; be.resp = 2'b10;
    bExpQ.push_back(be);
    awSend(1, 'h200, 1, 2, INCR);
    wSend(32'hAAAA0001, 4'hF, 1'b1);
    wSend(32'hAAAA0002, 4'hF, 1'b1);
    bRecv(1'b0);
    expectR(1, 32'hAAAA0001, 0, 1'b0);
    expectR(1, 32'hAAAA0002, 0, 1'b1);
    arSend(1, 'h200, 1, 2, INCR);
    rRecv(2, 1'b0);

    $display("[TB] backpressure on B and R");
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(rep, 'h300, 2, 2, INCR, 32'h30000000 + 32'(rep * 'h100), 32'h10, 4'hF,
                    0, 1'b1);
      for (int i = 0; i < 3; i++)
        expectR(rep + 2, 32'h30000000 + 32'(rep * 'h100) + 32'(i * 'h10), 0, i == 2);
      arSend(rep + 2, 'h300, 2, 2, INCR);
      rRecv(3, 1'b1);
    end

    $display("[TB] simultaneous read and write of one word");
    applyStimulus(0, 'h40, 0, 2, INCR, 32'h11111111, 32'd0, 4'hF, 0, 1'b0);
    be.id = 2'd0; be.resp = 2'b00;
    bExpQ.push_back(be);
    expectR(3, 32'h11111111, 0, 1'b1);
    awSend(0, 'h40, 0, 2, INCR);
    i_wsdata = 32'h22222222; i_wsstrb = 4'hF; i_ws_last = 1'b1; i_wsvalid = 1'b1;
    i_arsid = 2'd3; i_arsaddr = AW'('h40); i_ars_len = 8'd0; i_ars_size = 3'd2;
    i_ars_burst = INCR; i_arsvalid = 1'b1;
    checkOutput("concurrent_ready", 64'({o_wsready, o_arsready}), 64'(2'b11));
    @(negedge clk);
    i_wsvalid = 1'b0; i_ws_last = 1'b0; i_arsvalid = 1'b0;
    rRecv(1, 1'b0);
    bRecv(1'b0);
    expectR(1, 32'h22222222, 0, 1'b1);
    arSend(1, 'h40, 0, 2, INCR);
    rRecv(1, 1'b0);

    $display("[TB] reset in the middle of a read burst");
    applyStimulus(0, 'h500, 3, 2, INCR, 32'h50000000, 32'd1, 4'hF, 0, 1'b0);
    for (int i = 0; i < 4; i++) expectR(2, 32'h50000000 + 32'(i), 0, i == 3);
    arSend(2, 'h500, 3, 2, INCR);
    rRecv(1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 64'({o_rsvalid, o_arsready, o_awsready}), 64'(3'b011));
    rExpQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ar_ready_after_rst", 64'({o_arsready, o_rsvalid}), 64'(2'b10));
    for (int i = 0; i < 4; i++) expectR(1, 32'h50000000 + 32'(i), 0, i == 3);
    arSend(1, 'h500, 3, 2, INCR);
    rRecv(4, 1'b0);

    checkOutput("scoreboard_drained", 64'(rExpQ.size() + bExpQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
